// File: rtl/ps2_keyboard_receiver_if.sv
// Keyboard-side bus for the PS/2 receiver: raw pins in, KBDR data, status and pop strobe.
// The receiver uses the slave modport; whatever drives the pins and pops uses master.
interface ps2_keyboard_receiver_if;
  logic        PS2_CLK;
  logic        PS2_DAT;
  logic        KB_Pop;
  logic [15:0] Data_ToMCU;
  logic        KB_Ready;
  logic        Frame_Err;
  logic        Overflow;

  modport master (
    output PS2_CLK, PS2_DAT, KB_Pop,
    input  Data_ToMCU, KB_Ready, Frame_Err, Overflow
  );

  modport slave (
    input  PS2_CLK, PS2_DAT, KB_Pop,
    output Data_ToMCU, KB_Ready, Frame_Err, Overflow
  );
endinterface

// File: rtl/ps2_keyboard_receiver.sv
// PS/2 keyboard frame receiver with a show-ahead scancode FIFO feeding KBDR.
// Pins are synchronised into Clk; a frame aborts if PS2_CLK stops falling for too long.
module ps2_keyboard_receiver #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                     Clk,
  input  logic                     Reset,
  ps2_keyboard_receiver_if.slave   kb
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int TCNT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } state_t;

  // Odd parity over data plus parity bit: the total count of ones must be odd.
  function automatic logic frame_parity_ok(input logic [7:0] data, input logic pbit);
    frame_parity_ok = ^{data, pbit};
  endfunction

  logic              clk_meta_r, clk_sync_r, clk_prev_r;
  logic              dat_meta_r, dat_sync_r;
  logic              fall_s, timeout_s, frame_ok_s;
  state_t            state_r, state_nxt_s;
  logic [2:0]        bitcnt_r;
  logic [7:0]        shift_r;
  logic              pbit_r;
  logic [TCNT_W-1:0] tcnt_r;
  logic              start_s, shift_en_s, pbit_en_s, push_s, err_s;
  logic              frame_err_r;
  logic [7:0]        fifo_mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r, rd_ptr_r;
  logic [CNT_W-1:0]  count_r;
  logic              overflow_r;
  logic              fifo_full_s, fifo_empty_s, wr_en_s, rd_en_s, ovf_set_s;

  // Two-flop synchronisers on both pins plus a history flop for clock-fall detection.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      clk_meta_r <= 1'b1;
      clk_sync_r <= 1'b1;
      clk_prev_r <= 1'b1;
      dat_meta_r <= 1'b1;
      dat_sync_r <= 1'b1;
    end else begin
      clk_meta_r <= kb.PS2_CLK;
      clk_sync_r <= clk_meta_r;
      clk_prev_r <= clk_sync_r;
      dat_meta_r <= kb.PS2_DAT;
      dat_sync_r <= dat_meta_r;
    end
  end

  assign fall_s     = clk_prev_r & ~clk_sync_r;
  assign frame_ok_s = dat_sync_r & frame_parity_ok(shift_r, pbit_r);
  // A clock fall in the same cycle always beats the timeout.
  assign timeout_s  = (state_r != ST_IDLE) & ~fall_s &
                      (tcnt_r == TCNT_W'(TIMEOUT_CYCLES - 1));

  // Frame FSM state register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Frame FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (fall_s && !dat_sync_r) state_nxt_s = ST_DATA;
        else                       state_nxt_s = ST_IDLE;
      end
      ST_DATA: begin
        if (fall_s)         state_nxt_s = (bitcnt_r == 3'd7) ? ST_PARITY : ST_DATA;
        else if (timeout_s) state_nxt_s = ST_IDLE;
        else                state_nxt_s = ST_DATA;
      end
      ST_PARITY: begin
        if (fall_s)         state_nxt_s = ST_STOP;
        else if (timeout_s) state_nxt_s = ST_IDLE;
        else                state_nxt_s = ST_PARITY;
      end
      ST_STOP: begin
        if (fall_s || timeout_s) state_nxt_s = ST_IDLE;
        else                     state_nxt_s = ST_STOP;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Frame FSM outputs: datapath enables, FIFO push and error strobe.
  always_comb begin
    start_s    = 1'b0;
    shift_en_s = 1'b0;
    pbit_en_s  = 1'b0;
    push_s     = 1'b0;
    err_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        start_s = fall_s & ~dat_sync_r;
      end
      ST_DATA: begin
        shift_en_s = fall_s;
        err_s      = timeout_s;
      end
      ST_PARITY: begin
        pbit_en_s = fall_s;
        err_s     = timeout_s;
      end
      ST_STOP: begin
        push_s = fall_s & frame_ok_s;
        err_s  = (fall_s & ~frame_ok_s) | timeout_s;
      end
      default: begin
        err_s = 1'b0;
      end
    endcase
  end

  // Serial datapath: LSB-first shift register, bit counter, parity bit, inactivity timer.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      bitcnt_r <= 3'd0;
      shift_r  <= 8'h00;
      pbit_r   <= 1'b0;
      tcnt_r   <= '0;
    end else begin
      if (start_s) begin
        bitcnt_r <= 3'd0;
      end else if (shift_en_s) begin
        shift_r  <= {dat_sync_r, shift_r[7:1]};
        bitcnt_r <= bitcnt_r + 3'd1;
      end
      if (pbit_en_s) pbit_r <= dat_sync_r;
      if (fall_s || state_nxt_s == ST_IDLE) tcnt_r <= '0;
      else                                  tcnt_r <= tcnt_r + TCNT_W'(1);
    end
  end

  assign fifo_full_s  = (count_r == CNT_W'(FIFO_DEPTH));
  assign fifo_empty_s = (count_r == CNT_W'(0));
  assign rd_en_s      = kb.KB_Pop & ~fifo_empty_s;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign wr_en_s      = push_s & (~fifo_full_s | rd_en_s);
  assign ovf_set_s    = push_s & fifo_full_s & ~rd_en_s;

  // Scancode FIFO storage, pointers, occupancy and sticky overflow flag.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      count_r    <= '0;
      overflow_r <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem_r[i] <= 8'h00;
    end else begin
      if (wr_en_s) begin
        fifo_mem_r[wr_ptr_r] <= shift_r;
        wr_ptr_r             <= wr_ptr_r + PTR_W'(1);
      end
      if (rd_en_s) rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      case ({wr_en_s, rd_en_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
      if (ovf_set_s) overflow_r <= 1'b1;
    end
  end

  // Error strobe registered so it appears the cycle after detection.
  always_ff @(posedge Clk) begin
    if (Reset) frame_err_r <= 1'b0;
    else       frame_err_r <= err_s;
  end

  assign kb.Data_ToMCU = fifo_empty_s ? 16'h0000 : {8'h00, fifo_mem_r[rd_ptr_r]};
  assign kb.KB_Ready   = ~fifo_empty_s;
  assign kb.Frame_Err  = frame_err_r;
  assign kb.Overflow   = overflow_r;

endmodule

// File: tb/tb_ps2_keyboard_receiver.sv
// Randomised and directed bench for ps2_keyboard_receiver against a queue-based model.
module tb_ps2_keyboard_receiver;

  localparam int DEPTH = 4;
  localparam int TO    = 300;
  localparam int H     = 6;

  logic Clk   = 1'b0;
  logic Reset = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   err_hi_cnt = 0;
  int   exp_err    = 0;
  logic [7:0] ref_q[$];
  logic       ref_ovf = 1'b0;

  ps2_keyboard_receiver_if kb_if ();

  ps2_keyboard_receiver #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .kb    (kb_if.slave)
  );

  always #5 Clk = ~Clk;

  always @(negedge Clk) begin
    if (kb_if.Frame_Err === 1'b1) err_hi_cnt <= err_hi_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_data();
    return (ref_q.size() == 0) ? 16'h0000 : {8'h00, ref_q[0]};
  endfunction

  task automatic check_state(input string tag);
    @(negedge Clk);
    chk({tag, "_data"}, 32'(kb_if.Data_ToMCU), 32'(exp_data()));
    chk({tag, "_rdy"},  32'(kb_if.KB_Ready),   32'(ref_q.size() != 0));
    chk({tag, "_ovf"},  32'(kb_if.Overflow),   32'(ref_ovf));
    chk({tag, "_errs"}, 32'(err_hi_cnt),       32'(exp_err));
  endtask

  function automatic logic [10:0] make_frame(input logic [7:0] d, input logic par_flip,
                                             input logic stop_v);
    return {stop_v, (~^d) ^ par_flip, d, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] bits, input int nbits, input bit pop_at_stop,
                           output logic rdy_n, output logic rdy_n1, output logic err_n1);
    rdy_n = 1'b0; rdy_n1 = 1'b0; err_n1 = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      @(negedge Clk);
      kb_if.PS2_DAT = bits[i];
      repeat (H - 1) @(negedge Clk);
      kb_if.PS2_CLK = 1'b0;
      if (i == 10) begin
        @(negedge Clk);
        @(negedge Clk);
        rdy_n = kb_if.KB_Ready;
        if (pop_at_stop) begin
          chk("stop_pop_head", 32'(kb_if.Data_ToMCU), 32'(exp_data()));
          kb_if.KB_Pop = 1'b1;
        end
        @(negedge Clk);
        kb_if.KB_Pop = 1'b0;
        rdy_n1 = kb_if.KB_Ready;
        err_n1 = kb_if.Frame_Err;
        repeat (H - 3) @(negedge Clk);
      end else begin
        repeat (H) @(negedge Clk);
      end
      kb_if.PS2_CLK = 1'b1;
    end
    kb_if.PS2_DAT = 1'b1;
    repeat (H) @(negedge Clk);
  endtask

  task automatic do_frame(input string tag, input logic [7:0] d, input logic par_flip,
                          input logic stop_v, input bit pop_at_stop);
    logic rdy_n, rdy_n1, err_n1, good;
    int   size_before;
    good        = !par_flip && stop_v;
    size_before = ref_q.size();
    send_bits(make_frame(d, par_flip, stop_v), 11, pop_at_stop, rdy_n, rdy_n1, err_n1);
    if (pop_at_stop && ref_q.size() != 0) void'(ref_q.pop_front());
    if (good) begin
      if (ref_q.size() < DEPTH) ref_q.push_back(d);
      else                      ref_ovf = 1'b1;
    end else begin
      exp_err++;
    end
    chk({tag, "_rdy_fall_cycle"}, 32'(rdy_n),  32'(size_before != 0));
    chk({tag, "_rdy_next_cycle"}, 32'(rdy_n1), 32'(ref_q.size() != 0));
    chk({tag, "_err_next_cycle"}, 32'(err_n1), 32'(!good));
    check_state(tag);
  endtask

  task automatic do_pop(input string tag);
    @(negedge Clk);
    chk({tag, "_head"}, 32'(kb_if.Data_ToMCU), 32'(exp_data()));
    kb_if.KB_Pop = 1'b1;
    @(negedge Clk);
    kb_if.KB_Pop = 1'b0;
    if (ref_q.size() != 0) void'(ref_q.pop_front());
    check_state(tag);
  endtask

  task automatic do_reset(input string tag);
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    chk({tag, "_data"}, 32'(kb_if.Data_ToMCU), 32'h0);
    chk({tag, "_rdy"},  32'(kb_if.KB_Ready),   32'h0);
    chk({tag, "_err"},  32'(kb_if.Frame_Err),  32'h0);
    chk({tag, "_ovf"},  32'(kb_if.Overflow),   32'h0);
    Reset = 1'b0;
    ref_q.delete();
    ref_ovf = 1'b0;
  endtask

  initial begin
    logic dummy_a, dummy_b, dummy_c;
    kb_if.PS2_CLK = 1'b1;
    kb_if.PS2_DAT = 1'b1;
    kb_if.KB_Pop  = 1'b0;
    repeat (3) @(negedge Clk);
    do_reset("reset");

    do_frame("t1_1c", 8'h1C, 1'b0, 1'b1, 1'b0);
    chk("t1_data", 32'(kb_if.Data_ToMCU), 32'h001C);
    do_pop("t1_pop");
    chk("t1_empty_data", 32'(kb_if.Data_ToMCU), 32'h0000);

    do_frame("t2_badpar", 8'h1C, 1'b1, 1'b1, 1'b0);
    do_frame("t2_32", 8'h32, 1'b0, 1'b1, 1'b0);
    chk("t2_data", 32'(kb_if.Data_ToMCU), 32'h0032);
    do_pop("t2_pop");

    for (int i = 1; i <= 5; i++) do_frame("t3_fill", 8'(i), 1'b0, 1'b1, 1'b0);
    chk("t3_ovf", 32'(kb_if.Overflow), 32'h1);
    for (int i = 1; i <= 4; i++) begin
      chk("t3_drain_head", 32'(kb_if.Data_ToMCU), 32'(i));
      do_pop("t3_pop");
    end
    chk("t3_rdy_done", 32'(kb_if.KB_Ready), 32'h0);

    send_bits(make_frame(8'hA5, 1'b0, 1'b1), 4, 1'b0, dummy_a, dummy_b, dummy_c);
    repeat (TO + 20) @(negedge Clk);
    exp_err++;
    check_state("t4_timeout");
    do_frame("t4_f0", 8'hF0, 1'b0, 1'b1, 1'b0);
    chk("t4_data", 32'(kb_if.Data_ToMCU), 32'h00F0);

    do_reset("t5_reset");
    for (int i = 2; i <= 5; i++) do_frame("t5_fill", 8'(i), 1'b0, 1'b1, 1'b0);
    do_frame("t5_pushpop", 8'h2A, 1'b0, 1'b1, 1'b1);
    chk("t5_ovf", 32'(kb_if.Overflow), 32'h0);
    chk("t5_head", 32'(kb_if.Data_ToMCU), 32'h0003);
    for (int i = 0; i < 4; i++) do_pop("t5_drain");
    chk("t5_rdy_done", 32'(kb_if.KB_Ready), 32'h0);

    do_frame("t6_q1", 8'h11, 1'b0, 1'b1, 1'b0);
    do_frame("t6_q2", 8'h22, 1'b0, 1'b1, 1'b0);
    send_bits(make_frame(8'h77, 1'b0, 1'b1), 6, 1'b0, dummy_a, dummy_b, dummy_c);
    do_reset("t6_reset");
    do_frame("t6_5a", 8'h5A, 1'b0, 1'b1, 1'b0);
    chk("t6_data", 32'(kb_if.Data_ToMCU), 32'h005A);

    for (int n = 0; n < 40; n++) begin
      int unsigned op;
      logic [7:0]  d;
      op = $urandom_range(0, 9);
      d  = 8'($urandom);
      if (op <= 4)      do_frame("rnd_good", d, 1'b0, 1'b1, 1'b0);
      else if (op == 5) do_frame("rnd_badpar", d, 1'b1, 1'b1, 1'b0);
      else if (op == 6) do_frame("rnd_badstop", d, 1'b0, 1'b0, 1'b0);
      else              do_pop("rnd_pop");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
